// File: rtl/stream_scrambler_par.sv
`default_nettype none
// ============================================================================
//  Module   : stream_scrambler_par
//  Brief    : Parallel additive scrambler, DW keystream bits per accepted beat
//             from a two-tap Fibonacci LFSR. Optional zero-seed guard selected
//             by macro SCR_LOCKUP_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_scrambler_par #(
    parameter int DW     = 3,
    parameter int LFSR_W = 33,
    parameter int TAP_M  = 20,
    parameter int TAP_S  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              mode,
    input  logic              scr_en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic              locked_up,
    output logic              busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_adv;
    logic [LFSR_W-1:0] w_seed_eff;
    logic              r_mode;
    logic              r_m_valid;
    logic [DW-1:0]     r_m_data;
    logic [DW-1:0]     w_ks;
    logic              w_fb;
    logic              w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (load) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy     = (r_state == RUN);
    assign s_ready  = (r_state == RUN) && !load && (!r_m_valid || m_ready);
    assign w_accept = s_valid && s_ready;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;

`ifdef SCR_LOCKUP_GUARD_EN
    logic w_zero_seed;
    logic r_locked_up;

    assign w_zero_seed = load && (seed == '0);
    assign w_seed_eff  = w_zero_seed ? {LFSR_W{1'b1}} : seed;
    assign locked_up   = r_locked_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked_up <= 1'b0;
        end else begin
            r_locked_up <= w_zero_seed;
        end
    end
`else
    assign w_seed_eff = seed;
    assign locked_up  = 1'b0;
`endif

    // Unroll DW serial steps; keystream bit i is the feedback of step i.
    always_comb begin
        w_lfsr_adv = r_lfsr;
        w_ks       = '0;
        w_fb       = 1'b0;
        for (int i = 0; i < DW; i++) begin
            w_fb       = w_lfsr_adv[LFSR_W-1] ^
                         (r_mode ? w_lfsr_adv[TAP_S-1] : w_lfsr_adv[TAP_M-1]);
            w_ks[i]    = w_fb;
            w_lfsr_adv = {w_lfsr_adv[LFSR_W-2:0], w_fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= '0;
            r_mode <= 1'b0;
        end else if (load) begin
            r_lfsr <= w_seed_eff;
            r_mode <= mode;
        end else if (w_accept) begin
            r_lfsr <= w_lfsr_adv;
        end
    end

    // Output register: a pending beat survives load since accept is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= scr_en ? (s_data ^ w_ks) : s_data;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_scrambler_par.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_scrambler_par
//  Brief    : Directed self-checking bench for stream_scrambler_par; keystream
//             reference is a bit-recurrence b[n] = b[n-33] ^ b[n-T].
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_scrambler_par;

    localparam int DW = 3;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        load    = 1'b0;
    logic [32:0] seed    = '0;
    logic        mode    = 1'b0;
    logic        scr_en  = 1'b0;
    logic        s_valid = 1'b0;
    logic [2:0]  s_data  = '0;
    logic        m_ready = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [2:0]  m_data;
    logic        locked_up;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit hist [0:4095];
    int hn;
    int mtap;

    stream_scrambler_par #(
        .DW(DW), .LFSR_W(33), .TAP_M(20), .TAP_S(13)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .seed(seed), .mode(mode),
        .scr_en(scr_en), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .locked_up(locked_up), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // History holds the oldest seed bit (seed[32]) at index 0.
    task automatic m_load(input logic [32:0] sd, input logic md);
        for (int k = 0; k < 33; k++) hist[k] = sd[32-k];
        hn   = 33;
        mtap = md ? 13 : 20;
    endtask

    task automatic m_next(output logic [2:0] ks);
        ks = '0;
        for (int i = 0; i < DW; i++) begin
            hist[hn] = hist[hn-33] ^ hist[hn-mtap];
            ks[i]    = hist[hn];
            hn++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [32:0] sd, input logic md);
        seed = sd;
        mode = md;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // One accepted beat; expected output comes from the reference model.
    task automatic beat(input string tag, input logic [2:0] d, input logic en,
                        output logic [2:0] exp);
        logic [2:0] ks;
        s_valid = 1'b1;
        s_data  = d;
        scr_en  = en;
        m_next(ks);
        exp = en ? (d ^ ks) : d;
        tick();
        chk(tag, m_data, exp);
    endtask

    initial begin
        logic [2:0] d;
        logic [2:0] e;
        logic [2:0] p;
        logic [2:0] acc;

        // Reset state
        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_locked", locked_up, 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        tick();
        chk("idle_s_ready", s_ready, 0);
        chk("idle_m_valid", m_valid, 0);
        s_valid = 1'b0;

        // Case 1: hand-computed first beat
        do_load(33'h1_0000_0000, 1'b0);
        m_load(33'h1_0000_0000, 1'b0);
        chk("c1_busy", busy, 1);
        s_valid = 1'b1; s_data = 3'b000; scr_en = 1'b1;
        #1;
        chk("c1_s_ready", s_ready, 1);
        m_next(e);
        tick();
        chk("c1_m_data", m_data, 3'b001);
        chk("c1_m_valid", m_valid, 1);
        s_valid = 1'b0;
        tick();
        chk("c1_drain", m_valid, 0);
        tick();
        beat("c1_beat2", 3'b101, 1'b1, e);
        chk("c1_beat2_hand", m_data, 3'b101);

        // Case 2: long runs in slave and master mode, back-to-back beats
        s_valid = 1'b0;
        do_load(33'h1_0000_0000, 1'b1);
        m_load(33'h1_0000_0000, 1'b1);
        for (int n = 0; n < 1000; n++) begin
            d = 3'($urandom);
            beat("c2_slave", d, (n % 7) != 3, e);
        end
        chk("c2_valid", m_valid, 1);
        s_valid = 1'b0;
        do_load(33'h1_0000_0000, 1'b0);
        m_load(33'h1_0000_0000, 1'b0);
        for (int n = 0; n < 1000; n++) begin
            d = 3'($urandom);
            beat("c2_master", d, 1'b1, e);
        end

        // Case 3: output stall
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        beat("c3_first", 3'b110, 1'b1, p);
        s_data = 3'b011;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("c3_s_ready", s_ready, 0);
            chk("c3_hold", m_data, p);
            chk("c3_valid", m_valid, 1);
        end
        m_ready = 1'b1;
        beat("c3_resume0", 3'b011, 1'b1, e);
        beat("c3_resume1", 3'b100, 1'b1, e);
        beat("c3_resume2", 3'b001, 1'b1, e);

        // Case 4: load against a pending beat
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        beat("c4_pend", 3'b010, 1'b1, p);
        s_data = 3'b111;
        do_load(33'h0_1234_5678, 1'b0);
        m_load(33'h0_1234_5678, 1'b0);
        chk("c4_hold", m_data, p);
        chk("c4_valid", m_valid, 1);
        chk("c4_s_ready", s_ready, 0);
        m_ready = 1'b1;
        beat("c4_new0", 3'b111, 1'b1, e);
        beat("c4_new1", 3'b000, 1'b1, e);

        // Case 5: all-zero seed
        s_valid = 1'b0;
        do_load(33'h0, 1'b0);
`ifdef SCR_LOCKUP_GUARD_EN
        chk("c5_locked_pulse", locked_up, 1);
        m_load({33{1'b1}}, 1'b0);
`else
        chk("c5_locked_tied", locked_up, 0);
        m_load(33'h0, 1'b0);
`endif
        acc = '0;
        for (int n = 0; n < 12; n++) begin
            beat("c5_beat", 3'b000, 1'b1, e);
            acc = acc | m_data;
            chk("c5_locked_low", locked_up, 0);
        end
`ifdef SCR_LOCKUP_GUARD_EN
        chk("c5_nonzero", (acc != 3'b000), 1);
`else
        chk("c5_zero_ks", acc, 3'b000);
`endif

        // Case 6: reset mid-stream
        do_load(33'h1_5555_AAAA, 1'b1);
        m_load(33'h1_5555_AAAA, 1'b1);
        beat("c6_pre0", 3'b101, 1'b1, e);
        beat("c6_pre1", 3'b010, 1'b1, e);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c6_m_valid", m_valid, 0);
        chk("c6_s_ready", s_ready, 0);
        chk("c6_busy", busy, 0);
        chk("c6_m_data", m_data, 0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("c6_no_accept", s_ready, 0);
            chk("c6_no_valid", m_valid, 0);
        end
        do_load(33'h1_5555_AAAA, 1'b1);
        m_load(33'h1_5555_AAAA, 1'b1);
        beat("c6_post", 3'b101, 1'b1, e);
        chk("c6_post_valid", m_valid, 1);
        s_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
